// File: rtl/pc_counter_pkg.sv
// pc_counter_pkg: shared types and constants for the fetch-stage PC block.
// RV32 major opcode classes, data width, and the JALR target alignment helper.
package pc_counter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    LOAD   = 7'h03,
    I_TYPE = 7'h13,
    AUIPC  = 7'h17,
    S_TYPE = 7'h23,
    R_TYPE = 7'h33,
    LUI    = 7'h37,
    B_TYPE = 7'h63,
    JALR   = 7'h67,
    JAL    = 7'h6F
  } opcode_t;

  // JALR targets always have bit 0 cleared.
  function automatic logic [XLEN-1:0] jalr_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h1;
  endfunction

endpackage

// File: rtl/pc_counter_if.sv
// pc_counter_if: fetch-side bundle between the core control and the PC block.
// Optional macro PC_BRANCH_COND_EN adds the branch_taken_i condition signal.
interface pc_counter_if;
  import pc_counter_pkg::*;

  logic              enbl_i;
  opcode_t           opcode_i;
  logic [XLEN-1:0]   instruction;
`ifdef PC_BRANCH_COND_EN
  logic              branch_taken_i;
`endif
  logic [XLEN-1:0]   pc_o;
  logic [XLEN-1:0]   i_imm;
  logic [XLEN-1:0]   s_imm;
  logic [XLEN-1:0]   sb_imm;
  logic [XLEN-1:0]   uj_imm;
  logic [XLEN-1:0]   u_imm;

  // Core side: drives instruction stream and control, observes PC/immediates.
  modport master (
`ifdef PC_BRANCH_COND_EN
    output branch_taken_i,
`endif
    output enbl_i, opcode_i, instruction,
    input  pc_o, i_imm, s_imm, sb_imm, uj_imm, u_imm
  );

  // PC block side.
  modport slave (
`ifdef PC_BRANCH_COND_EN
    input  branch_taken_i,
`endif
    input  enbl_i, opcode_i, instruction,
    output pc_o, i_imm, s_imm, sb_imm, uj_imm, u_imm
  );

endinterface

// File: rtl/pc_counter_imm_gen.sv
// imm_gen: purely combinational RV32 immediate decoder (I, S, B, J, U formats).
module imm_gen
  import pc_counter_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_i_imm,
  output logic [XLEN-1:0] o_s_imm,
  output logic [XLEN-1:0] o_sb_imm,
  output logic [XLEN-1:0] o_uj_imm,
  output logic [XLEN-1:0] o_u_imm
);

  // Field extraction and sign extension from instruction bit 31.
  always_comb begin
    o_i_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
    o_s_imm  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    o_sb_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                i_instr[11:8], 1'b0};
    o_uj_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                i_instr[30:21], 1'b0};
    o_u_imm  = {i_instr[31:12], 12'h000};
  end

endmodule

// File: rtl/pc_counter.sv
// pc_counter: RV32 architectural PC register with next-PC selection.
// Optional macro PC_BRANCH_COND_EN: B_TYPE is taken only when branch_taken_i=1;
// without it every B_TYPE is treated as taken.
module pc_counter
  import pc_counter_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  pc_counter_if.slave  bus
);

  localparam logic [XLEN-1:0] LP_STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_i_imm;
  logic [XLEN-1:0] w_s_imm;
  logic [XLEN-1:0] w_sb_imm;
  logic [XLEN-1:0] w_uj_imm;
  logic [XLEN-1:0] w_u_imm;
  logic            w_taken;

  imm_gen u_imm_gen (
    .i_instr  (bus.instruction),
    .o_i_imm  (w_i_imm),
    .o_s_imm  (w_s_imm),
    .o_sb_imm (w_sb_imm),
    .o_uj_imm (w_uj_imm),
    .o_u_imm  (w_u_imm)
  );

`ifdef PC_BRANCH_COND_EN
  assign w_taken = bus.branch_taken_i;
`else
  assign w_taken = 1'b1;
`endif

  // Next-PC mux; all sums wrap modulo 2^32, no alignment trap.
  always_comb begin
    w_next_pc = r_pc + LP_STEP;
    case (bus.opcode_i)
      B_TYPE:  if (w_taken) w_next_pc = r_pc + w_sb_imm;
      JAL:     w_next_pc = r_pc + w_uj_imm;
      JALR:    w_next_pc = jalr_align(r_pc + w_i_imm);
      default: w_next_pc = r_pc + LP_STEP;
    endcase
  end

  // PC register: async reset wins, otherwise load next PC on enabled edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc <= RESET_PC;
    end else if (bus.enbl_i) begin
      r_pc <= w_next_pc;
    end
  end

  assign bus.pc_o   = r_pc;
  assign bus.i_imm  = w_i_imm;
  assign bus.s_imm  = w_s_imm;
  assign bus.sb_imm = w_sb_imm;
  assign bus.uj_imm = w_uj_imm;
  assign bus.u_imm  = w_u_imm;

endmodule

// File: tb/tb_pc_counter.sv
// tb_pc_counter: directed vectors with a queue-based scoreboard for pc_counter.
module tb_pc_counter;
  import pc_counter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pc_counter_if bus ();

  pc_counter #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    bit          chk_imm;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] sb_imm;
    logic [31:0] uj_imm;
    logic [31:0] u_imm;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the PC expected after the next rising edge.
  task automatic step(input string nm, input logic en, input opcode_t op, input logic [31:0] ins,
                      input logic [31:0] pc_exp, input bit ci,
                      input logic [31:0] ei, input logic [31:0] es, input logic [31:0] esb,
                      input logic [31:0] euj, input logic [31:0] eu);
    exp_t e;
    @(negedge clk);
    bus.enbl_i      = en;
    bus.opcode_i    = op;
    bus.instruction = ins;
    e.name    = nm;
    e.pc      = pc_exp;
    e.chk_imm = ci;
    e.i_imm   = ei;
    e.s_imm   = es;
    e.sb_imm  = esb;
    e.uj_imm  = euj;
    e.u_imm   = eu;
    q.push_back(e);
  endtask

  task automatic stp(input string nm, input logic en, input opcode_t op, input logic [31:0] ins,
                     input logic [31:0] pc_exp);
    step(nm, en, op, ins, pc_exp, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Monitor: shortly after each rising edge, pop and compare whatever is outstanding.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        m = q.pop_front();
        chk({m.name, "/pc"}, bus.pc_o, m.pc);
        if (m.chk_imm) begin
          chk({m.name, "/i_imm"},  bus.i_imm,  m.i_imm);
          chk({m.name, "/s_imm"},  bus.s_imm,  m.s_imm);
          chk({m.name, "/sb_imm"}, bus.sb_imm, m.sb_imm);
          chk({m.name, "/uj_imm"}, bus.uj_imm, m.uj_imm);
          chk({m.name, "/u_imm"},  bus.u_imm,  m.u_imm);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    bus.enbl_i      = 1'b0;
    bus.opcode_i    = R_TYPE;
    bus.instruction = 32'h0000_0033;
`ifdef PC_BRANCH_COND_EN
    bus.branch_taken_i = 1'b1;
`endif
    #12;
    chk("reset_state", bus.pc_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    stp("seq_a1", 1'b1, R_TYPE, 32'h0000_0033, 32'h4);
    stp("seq_a2", 1'b1, R_TYPE, 32'h0000_0033, 32'h8);
    stp("jal_a",  1'b1, JAL,    32'h0034_5678, 32'h0004_580A);

    // Asynchronous reset mid-cycle with an update pending.
    @(negedge clk);
    bus.enbl_i      = 1'b1;
    bus.opcode_i    = R_TYPE;
    bus.instruction = 32'h0034_5678;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", bus.pc_o, 32'h0);
    chk("imm_in_rst", bus.i_imm, 32'h3);
    @(posedge clk);
    #2;
    chk("rst_hold", bus.pc_o, 32'h0);
    @(negedge clk);
    bus.enbl_i = 1'b0;
    rst_n      = 1'b1;

    stp("seq_b1", 1'b1, R_TYPE, 32'h0000_0033, 32'h4);
    stp("seq_b2", 1'b1, R_TYPE, 32'h0000_0033, 32'h8);
    stp("seq_b3", 1'b1, R_TYPE, 32'h0000_0033, 32'hC);
    step("br_neg", 1'b1, B_TYPE, 32'hFE00_0EE3, 32'h8, 1'b1,
         32'hFFFF_FFE0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFF0_07E0, 32'hFE00_0000);
    step("br_pos", 1'b1, B_TYPE, 32'h0034_5678, 32'h14, 1'b1,
         32'h0000_0003, 32'h0000_000C, 32'h0000_000C, 32'h0004_5802, 32'h0034_5000);
    stp("br_back", 1'b1, B_TYPE, 32'hFE00_0EE3, 32'h10);
    stp("jalr_a",  1'b1, JALR,   32'h0030_0067, 32'h12);
    stp("hold1",   1'b0, JAL,    32'h0034_5678, 32'h12);
    stp("hold2",   1'b0, JAL,    32'h0034_5678, 32'h12);
    stp("hold3",   1'b0, JAL,    32'h0034_5678, 32'h12);
    stp("tog1",    1'b1, R_TYPE, 32'h0000_0033, 32'h16);
    stp("tog2",    1'b0, R_TYPE, 32'h0000_0033, 32'h16);
    stp("tog3",    1'b1, R_TYPE, 32'h0000_0033, 32'h1A);
    stp("tog4",    1'b0, R_TYPE, 32'h0000_0033, 32'h1A);

    // Plain reset back to zero.
    @(negedge clk);
    bus.enbl_i = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    chk("rst_again", bus.pc_o, 32'h0);
    rst_n = 1'b1;

    stp("br_under", 1'b1, B_TYPE, 32'hFE00_0EE3, 32'hFFFF_FFFC);
    stp("wrap",     1'b1, I_TYPE, 32'h0000_0013, 32'h0);
    stp("jal_0",    1'b1, JAL,    32'h0034_5678, 32'h0004_5802);
    stp("unlisted", 1'b1, opcode_t'(7'h7F), 32'h0000_007F, 32'h0004_5806);
    step("jalr_neg", 1'b1, JALR, 32'hFFF0_0067, 32'h0004_5804, 1'b1,
         32'hFFFF_FFFF, 32'hFFFF_FFE0, 32'hFFFF_F7E0, 32'hFFF0_0FFE, 32'hFFF0_0000);
`ifdef PC_BRANCH_COND_EN
    @(negedge clk);
    bus.branch_taken_i = 1'b0;
    stp("br_not_taken", 1'b1, B_TYPE, 32'hFE00_0EE3, 32'h0004_5808);
    @(negedge clk);
    bus.branch_taken_i = 1'b1;
    bus.enbl_i         = 1'b0;
`endif

    @(negedge clk);
    bus.enbl_i = 1'b0;
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_counter.md
Name: pc_counter

Overview:
- RV32 program-counter block for the single-issue core's fetch stage.
- Holds the architectural PC register.
- Decodes the five immediate formats (I, S, B, U, J) from the current instruction word.
- Selects the next PC from the current instruction class (opcode_i): sequential, branch, JAL, JALR. Updates only on enabled clock edges.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk_i  input  1  rising-edge clock
- rst_ni  input  1  asynchronous active-low reset
- enbl_i  input  1  PC update enable, sampled at the rising clk_i edge
- opcode_i  input  opcode (enum from package opcode)  class of the current instruction
- instruction  input  32  current instruction word
- pc_o  output  32  current PC (register output)
- i_imm  output  32  I-type immediate, sign-extended
- s_imm  output  32  S-type immediate, sign-extended
- sb_imm  output  32  B-type immediate, sign-extended, bit0=0
- uj_imm  output  32  J-type immediate, sign-extended, bit0=0
- u_imm  output  32  U-type immediate
- branch_taken_i  input  1  present only with PC_BRANCH_COND_EN

Behaviour:
- Reset:
  - rst_ni low forces pc_o=RESET_PC immediately, independent of clk_i.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation discards any pending update.
- Immediate outputs are purely combinational from instruction, zero latency, unaffected by reset or enable:
  - i_imm = sext(instr[31:20])
  - s_imm = sext({instr[31:25],instr[11:7]})
  - sb_imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - uj_imm = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - u_imm = {instr[31:12],12'h000}
- Next-PC selection, combinational on the current pc_o:
  - B_TYPE: pc_o + sb_imm
  - JAL: pc_o + uj_imm
  - JALR: (pc_o + i_imm) & ~32'h1 (no register operand available; relative form)
  - R_TYPE, I_TYPE, LOAD, S_TYPE, LUI, AUIPC and any unlisted encoding: pc_o + PC_STEP
- Update:
  - At a rising clk_i with rst_ni high and enbl_i=1: pc_o <= next PC.
  - With enbl_i=0: pc_o holds.
  - One cycle latency from inputs to pc_o.
- Arithmetic: all additions are modulo 2^32. Wrap-around is silent (32'hFFFF_FFFC + 4 = 0). No misalignment trap.
- Simultaneous events: reset dominates enable.

Optional Feature:
- PC_BRANCH_COND_EN defined: adds branch_taken_i. B_TYPE uses pc_o + sb_imm only when branch_taken_i=1, otherwise pc_o + PC_STEP.
- Undefined: port absent; B_TYPE is always taken.

Decomposition:
- Package opcode holds:
  - typedef enum logic [6:0] opcode with RV32 major opcodes: R_TYPE=7'h33, I_TYPE=7'h13, LOAD=7'h03, S_TYPE=7'h23, B_TYPE=7'h63, JAL=7'h6F, JALR=7'h67, LUI=7'h37, AUIPC=7'h17.
  - XLEN=32 constant.
- One natural sub-module: imm_gen (combinational immediate decoder, instruction -> five immediates), instantiated inside pc_counter.

Test Plan:
- Reset: rst_ni=0 asynchronously mid-cycle -> pc_o=0 immediately; release, enbl_i=1, opcode_i=R_TYPE, 3 edges -> pc_o=4,8,12.
- Immediates: instruction=32'h0034_5678 -> i_imm=3, s_imm=12, sb_imm=12, uj_imm=32'h0004_5802, u_imm=32'h0034_5000.
- Branch: pc_o=8, opcode_i=B_TYPE, instruction=32'h0034_5678 -> next pc_o=20. Same with instruction=32'hFE00_0EE3 (sb_imm=-4) -> pc_o=4.
- Jumps: pc_o=0, JAL, instruction=32'h0034_5678 -> pc_o=32'h0004_5802. From pc_o=16, JALR, instruction=32'h0030_0067 -> pc_o=19&~1=18.
- Enable: enbl_i=0 for 3 edges with opcode_i=JAL -> pc_o unchanged. enbl_i toggled each half-cycle -> update only on edges where enbl_i=1.
- Wrap: pc_o=32'hFFFF_FFFC, opcode_i=I_TYPE, enbl_i=1 -> pc_o=0.
